riscv_core_mdu_seq: RTL and testbench

//  Issue/writeback sequencer in front of the RV64M multiply/divide unit. Accepts one M-extension op

---
 rtl/riscv_core_mdu_seq.sv | 159 +++++++++++++++
 tb/tb_riscv_core_mdu_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_mdu_seq.sv
// Issue/writeback sequencer for the RV64M multiply/divide unit.
// Holds one op at a time: launches it, stalls the pipeline while the unit
// works, and presents the result on a valid/ready writeback port.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_IDLE  | ready for a new op
//  S_START | md_en pulse to the unit this cycle
//  S_WAIT  | unit busy, counting toward timeout
//  S_HOLD  | result held on writeback port until consumed
//  S_DRAIN | flushed op still in the unit, result will be discarded
module riscv_core_mdu_seq #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            i_mdu_seq_clk,
  input  logic            i_mdu_seq_rst,
  input  logic            i_mdu_seq_valid,
  output logic            o_mdu_seq_ready,
  input  logic [2:0]      i_mdu_seq_funct3,
  input  logic            i_mdu_seq_isword,
  input  logic [XLEN-1:0] i_mdu_seq_srcA,
  input  logic [XLEN-1:0] i_mdu_seq_srcB,
  input  logic [4:0]      i_mdu_seq_rd,
  input  logic            i_mdu_seq_flush,
  output logic            o_mdu_seq_md_en,
  output logic [2:0]      o_mdu_seq_md_control,
  output logic            o_mdu_seq_md_isword,
  output logic [XLEN-1:0] o_mdu_seq_md_srcA,
  output logic [XLEN-1:0] o_mdu_seq_md_srcB,
  input  logic            i_mdu_seq_md_done,
  input  logic [XLEN-1:0] i_mdu_seq_md_result,
  output logic            o_mdu_seq_wb_valid,
  input  logic            i_mdu_seq_wb_ready,
  output logic [4:0]      o_mdu_seq_wb_rd,
  output logic [XLEN-1:0] o_mdu_seq_wb_data,
  output logic            o_mdu_seq_stall,
  output logic            o_mdu_seq_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  localparam logic [7:0] CNT_TC = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [4:0] rd_q;
  logic       drain_done;
  logic       is_idle;
  logic       rd_nz;
  logic       launch;

  // Accept decode: a flush in IDLE blocks acceptance for that cycle.
  always_comb begin
    is_idle         = (state == S_IDLE);
    rd_nz           = (i_mdu_seq_rd != 5'd0);
    o_mdu_seq_ready = is_idle & ~i_mdu_seq_flush;
    launch          = i_mdu_seq_valid & o_mdu_seq_ready & rd_nz;
    o_mdu_seq_stall = ~is_idle | (i_mdu_seq_valid & rd_nz);
  end

  // Sequencer FSM with registered unit-side and writeback-side outputs.
  always_ff @(posedge i_mdu_seq_clk or posedge i_mdu_seq_rst) begin
    if (i_mdu_seq_rst) begin
      state                <= S_IDLE;
      cnt                  <= 8'd0;
      rd_q                 <= 5'd0;
      drain_done           <= 1'b0;
      o_mdu_seq_md_en      <= 1'b0;
      o_mdu_seq_md_control <= 3'd0;
      o_mdu_seq_md_isword  <= 1'b0;
      o_mdu_seq_md_srcA    <= '0;
      o_mdu_seq_md_srcB    <= '0;
      o_mdu_seq_wb_valid   <= 1'b0;
      o_mdu_seq_wb_rd      <= 5'd0;
      o_mdu_seq_wb_data    <= '0;
      o_mdu_seq_timeout    <= 1'b0;
    end else begin
      o_mdu_seq_md_en   <= 1'b0;
      o_mdu_seq_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= 8'd0;
          if (launch) begin
            o_mdu_seq_md_control <= i_mdu_seq_funct3;
            o_mdu_seq_md_isword  <= i_mdu_seq_isword;
            o_mdu_seq_md_srcA    <= i_mdu_seq_srcA;
            o_mdu_seq_md_srcB    <= i_mdu_seq_srcB;
            rd_q                 <= i_mdu_seq_rd;
            o_mdu_seq_md_en      <= 1'b1;
            state                <= S_START;
          end
        end
        S_START: begin
          cnt <= 8'd0;
          if (i_mdu_seq_flush) begin
            // A done coinciding with the flush is remembered so DRAIN exits at once.
            drain_done <= i_mdu_seq_md_done;
            state      <= S_DRAIN;
          end else if (i_mdu_seq_md_done) begin
            o_mdu_seq_wb_data  <= i_mdu_seq_md_result;
            o_mdu_seq_wb_rd    <= rd_q;
            o_mdu_seq_wb_valid <= 1'b1;
            state              <= S_HOLD;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_mdu_seq_flush) begin
            drain_done <= i_mdu_seq_md_done;
            state      <= S_DRAIN;
          end else if (i_mdu_seq_md_done) begin
            o_mdu_seq_wb_data  <= i_mdu_seq_md_result;
            o_mdu_seq_wb_rd    <= rd_q;
            o_mdu_seq_wb_valid <= 1'b1;
            state              <= S_HOLD;
          end else if (cnt >= CNT_TC) begin
            o_mdu_seq_timeout <= 1'b1;
            cnt               <= 8'd0;
            state             <= S_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_HOLD: begin
          // Flush together with wb_ready counts as consumed; both just retire.
          if (i_mdu_seq_wb_ready || i_mdu_seq_flush) begin
            o_mdu_seq_wb_valid <= 1'b0;
            state              <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (drain_done || i_mdu_seq_md_done) begin
            drain_done <= 1'b0;
            cnt        <= 8'd0;
            state      <= S_IDLE;
          end else if (cnt >= CNT_TC) begin
            o_mdu_seq_timeout <= 1'b1;
            cnt               <= 8'd0;
            state             <= S_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_core_mdu_seq.sv
// Directed bench for the M-extension issue/writeback sequencer.
module tb_riscv_core_mdu_seq;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid;
  logic            ready;
  logic [2:0]      funct3;
  logic            isword;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [4:0]      rd;
  logic            flush;
  logic            md_en;
  logic [2:0]      md_control;
  logic            md_isword;
  logic [XLEN-1:0] md_src_a;
  logic [XLEN-1:0] md_src_b;
  logic            md_done;
  logic [XLEN-1:0] md_result;
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            stall;
  logic            timeout;

  int total = 0;
  int bad   = 0;

  riscv_core_mdu_seq #(.XLEN(XLEN), .TIMEOUT(8)) dut (
    .i_mdu_seq_clk        (clk),
    .i_mdu_seq_rst        (rst),
    .i_mdu_seq_valid      (valid),
    .o_mdu_seq_ready      (ready),
    .i_mdu_seq_funct3     (funct3),
    .i_mdu_seq_isword     (isword),
    .i_mdu_seq_srcA       (src_a),
    .i_mdu_seq_srcB       (src_b),
    .i_mdu_seq_rd         (rd),
    .i_mdu_seq_flush      (flush),
    .o_mdu_seq_md_en      (md_en),
    .o_mdu_seq_md_control (md_control),
    .o_mdu_seq_md_isword  (md_isword),
    .o_mdu_seq_md_srcA    (md_src_a),
    .o_mdu_seq_md_srcB    (md_src_b),
    .i_mdu_seq_md_done    (md_done),
    .i_mdu_seq_md_result  (md_result),
    .o_mdu_seq_wb_valid   (wb_valid),
    .i_mdu_seq_wb_ready   (wb_ready),
    .o_mdu_seq_wb_rd      (wb_rd),
    .o_mdu_seq_wb_data    (wb_data),
    .o_mdu_seq_stall      (stall),
    .o_mdu_seq_timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are then driven 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op for one cycle; returns in the START cycle.
  task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] r);
    valid  = 1'b1;
    funct3 = f3;
    isword = w;
    src_a  = a;
    src_b  = b;
    rd     = r;
    step();
    valid = 1'b0;
    #1;
  endtask

  logic [4:0]  hold_rd;
  logic [63:0] hold_data;

  initial begin
    rst = 1'b1; valid = 0; funct3 = 0; isword = 0; src_a = 0; src_b = 0; rd = 0;
    flush = 0; md_done = 0; md_result = 0; wb_ready = 0;
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_md_en", md_en, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_wb_data", wb_data, 0);
    rst = 1'b0;
    step();

    // MUL 6*7 -> rd 5, done 3 cycles after md_en
    valid = 1; funct3 = 3'b000; isword = 0; src_a = 6; src_b = 7; rd = 5;
    #1;
    chk("mul_acc_ready", ready, 1);
    chk("mul_acc_stall", stall, 1);
    step(); valid = 0; #1;
    chk("mul_md_en", md_en, 1);
    chk("mul_md_a", md_src_a, 6);
    chk("mul_md_b", md_src_b, 7);
    chk("mul_md_ctl", md_control, 0);
    chk("mul_start_ready", ready, 0);
    step();
    chk("mul_md_en_pulse", md_en, 0);
    chk("mul_stall_w1", stall, 1);
    step();
    chk("mul_stall_w2", stall, 1);
    step();
    md_done = 1; md_result = 42; #1;
    chk("mul_no_wb_yet", wb_valid, 0);
    step(); md_done = 0; md_result = 0; #1;
    chk("mul_wb_valid", wb_valid, 1);
    chk("mul_wb_rd", wb_rd, 5);
    chk("mul_wb_data", wb_data, 42);
    chk("mul_hold_stall", stall, 1);
    wb_ready = 1;
    step(); wb_ready = 0; #1;
    chk("mul_done_valid", wb_valid, 0);
    chk("mul_done_ready", ready, 1);
    chk("mul_done_stall", stall, 0);

    // DIVUW by zero, done in START cycle, then 4 cycles of backpressure
    issue(3'b101, 1'b1, 100, 0, 7);
    md_done = 1; md_result = 64'hFFFF_FFFF_FFFF_FFFF; #1;
    chk("divu_md_en", md_en, 1);
    chk("divu_md_ctl", md_control, 5);
    chk("divu_md_isword", md_isword, 1);
    step(); md_done = 0; md_result = 0; #1;
    chk("divu_wb_valid", wb_valid, 1);
    chk("divu_wb_data", wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("divu_wb_rd", wb_rd, 7);
    hold_rd = 5'd7;
    hold_data = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_valid", wb_valid, 1);
      chk("hold_rd", wb_rd, hold_rd);
      chk("hold_data", wb_data, hold_data);
    end
    wb_ready = 1; valid = 1; funct3 = 3'b000; rd = 9; src_a = 1; src_b = 1; #1;
    chk("hs_no_accept", ready, 0);
    step(); wb_ready = 0; valid = 0; #1;
    chk("hs_idle_ready", ready, 1);
    chk("hs_no_md_en", md_en, 0);
    chk("hs_wb_valid", wb_valid, 0);

    // REM to x0: accepted and dropped
    valid = 1; funct3 = 3'b110; rd = 0; src_a = 9; src_b = 4; #1;
    chk("rem0_ready", ready, 1);
    chk("rem0_stall", stall, 0);
    step(); valid = 0; #1;
    chk("rem0_md_en", md_en, 0);
    chk("rem0_ready2", ready, 1);
    step();
    chk("rem0_md_en2", md_en, 0);
    chk("rem0_wb_valid", wb_valid, 0);

    // Flush 2 cycles after md_en, done 5 cycles later
    issue(3'b000, 1'b0, 3, 4, 10);
    step();
    step();
    flush = 1; #1;
    chk("fl_ready", ready, 0);
    step(); flush = 0; #1;
    chk("fl_drain_wb", wb_valid, 0);
    chk("fl_drain_stall", stall, 1);
    chk("fl_drain_ready", ready, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fl_drain_hold", ready, 0);
    end
    md_done = 1; md_result = 12; #1;
    step(); md_done = 0; #1;
    chk("fl_end_ready", ready, 1);
    chk("fl_end_wb", wb_valid, 0);
    chk("fl_end_stall", stall, 0);

    // Timeout: no done, TIMEOUT=8
    issue(3'b100, 1'b0, 1, 1, 11);
    step();
    for (int i = 0; i < 7; i++) begin
      step();
      chk("to_wait", timeout, 0);
    end
    step();
    chk("to_pulse", timeout, 1);
    chk("to_ready", ready, 1);
    chk("to_wb", wb_valid, 0);
    step();
    chk("to_pulse_end", timeout, 0);
    chk("to_ready2", ready, 1);

    // Flush in HOLD drops wb_valid
    issue(3'b001, 1'b0, 2, 2, 3);
    md_done = 1; md_result = 77; #1;
    step(); md_done = 0; #1;
    chk("hfl_valid", wb_valid, 1);
    flush = 1;
    step(); flush = 0; #1;
    chk("hfl_dropped", wb_valid, 0);
    chk("hfl_ready", ready, 1);

    // Flush and done together in WAIT: brief DRAIN then IDLE, result dropped
    issue(3'b111, 1'b0, 5, 3, 4);
    step();
    flush = 1; md_done = 1; md_result = 2; #1;
    step(); flush = 0; md_done = 0; #1;
    chk("fd_wb", wb_valid, 0);
    chk("fd_stall", stall, 1);
    step();
    chk("fd_ready", ready, 1);
    chk("fd_wb2", wb_valid, 0);

    // Async reset mid-WAIT
    issue(3'b000, 1'b0, 2, 3, 12);
    step();
    #1; rst = 1; #1;
    chk("ar_ready", ready, 1);
    chk("ar_stall", stall, 0);
    chk("ar_md_en", md_en, 0);
    chk("ar_md_a", md_src_a, 0);
    chk("ar_wb_data", wb_data, 0);
    chk("ar_wb_rd", wb_rd, 0);
    #1; rst = 0;
    step();
    chk("ar_after_ready", ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
